// File: rtl/jy_irq_pkg.sv
// Shared types and constants for the J.Y. Company mapper IRQ timer.
package jy_irq_pkg;

  // Timer life cycle: idle, counting, counting with IRQ raised
  typedef enum logic [1:0] {
    JY_IRQ_OFF  = 2'd0,
    JY_IRQ_RUN  = 2'd1,
    JY_IRQ_PEND = 2'd2
  } jy_irq_state_e;

  // Register offsets inside the $C000-$C007 window
  localparam logic [2:0] REG_ENABLE_CTL = 3'd0;
  localparam logic [2:0] REG_MODE       = 3'd1;
  localparam logic [2:0] REG_DISABLE    = 3'd2;
  localparam logic [2:0] REG_ENABLE     = 3'd3;
  localparam logic [2:0] REG_PRESC      = 3'd4;
  localparam logic [2:0] REG_COUNT      = 3'd5;
  localparam logic [2:0] REG_XOR        = 3'd6;

  // Mode register field positions
  localparam int MODE_DIR_HI = 7;
  localparam int MODE_DIR_LO = 6;
  localparam int MODE_PRE3   = 2;
  localparam int MODE_SRC_HI = 1;
  localparam int MODE_SRC_LO = 0;

  // Direction codes (00 and 11 both mean halt)
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  // Clock source codes
  localparam logic [1:0] SRC_M2    = 2'd0;
  localparam logic [1:0] SRC_A12   = 2'd1;
  localparam logic [1:0] SRC_PPURD = 2'd2;
  localparam logic [1:0] SRC_CPUWR = 2'd3;

  // Result of one prescaler step: new value plus carry/borrow into the counter
  typedef struct packed {
    logic [7:0] value;
    logic       carry;
  } jy_step_t;

  // One prescaler step; in 3-bit mode the carry comes from the low three bits
  // but all eight bits still move.
  function automatic jy_step_t presc_step(input logic [7:0] v, input logic up,
                                          input logic pre3);
    jy_step_t r;
    if (up) begin
      r.value = v + 8'd1;
      r.carry = pre3 ? (v[2:0] == 3'd7) : (v == 8'hFF);
    end else begin
      r.value = v - 8'd1;
      r.carry = pre3 ? (v[2:0] == 3'd0) : (v == 8'h00);
    end
    return r;
  endfunction

endpackage

// File: rtl/jy_irq_source.sv
// Clock-source selection for the IRQ timer: A12 rise detector with an optional
// low-time filter, and the four-way mux producing a single-cycle tick.
module jy_irq_source
  import jy_irq_pkg::*;
#(
  parameter int A12_FILTER = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_i,
  input  logic       ppu_ce_i,
  input  logic       prg_write_i,
  input  logic       chr_read_i,
  input  logic       chr_a12_i,
  input  logic [1:0] src_i,
  output logic       tick_o
);

  logic hist_q;
  logic hist_d;
  logic filt_ok_s;
  logic a12_rise_s;

  // A12 history follows the pin on every PPU cycle
  always_comb begin
    hist_d = hist_q;
    if (ppu_ce_i) begin
      hist_d = chr_a12_i;
    end else begin
      hist_d = hist_q;
    end
  end

  // A12 history register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
    end
  end

  generate
    if (A12_FILTER == 0) begin : g_nofilt
      assign filt_ok_s = 1'b1;
    end else begin : g_filt
      localparam int LW = $clog2(A12_FILTER + 1);
      localparam logic [LW-1:0] FILT = LW'(A12_FILTER);
      logic [LW-1:0] low_q;
      logic [LW-1:0] low_d;

      // Count PPU cycles A12 has been low, saturating at the filter length
      always_comb begin
        low_d = low_q;
        if (!ppu_ce_i) begin
          low_d = low_q;
        end else if (chr_a12_i) begin
          low_d = '0;
        end else if (low_q != FILT) begin
          low_d = low_q + 1'b1;
        end else begin
          low_d = low_q;
        end
      end

      // Low-run counter register
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          low_q <= '0;
        end else begin
          low_q <= low_d;
        end
      end

      assign filt_ok_s = (low_q == FILT);
    end
  endgenerate

  assign a12_rise_s = ppu_ce_i && chr_a12_i && !hist_q && filt_ok_s;

  // Select the active clock source
  always_comb begin
    tick_o = 1'b0;
    case (src_i)
      SRC_M2:    tick_o = ce_i;
      SRC_A12:   tick_o = a12_rise_s;
      SRC_PPURD: tick_o = ppu_ce_i && chr_read_i;
      SRC_CPUWR: tick_o = ce_i && prg_write_i;
      default:   tick_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/jy_irq_timer.sv
// J.Y. Company mapper IRQ timer: register window, enable FSM and the
// prescaler/counter pair that raises a sticky IRQ on counter wrap.
module jy_irq_timer
  import jy_irq_pkg::*;
#(
  parameter int A12_FILTER = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       ppu_ce,
  input  logic       reg_wr,
  input  logic [2:0] reg_addr,
  input  logic [7:0] reg_din,
  input  logic       prg_write,
  input  logic       chr_read,
  input  logic       chr_a12,
  output logic       irq,
  output logic [7:0] mode_o,
  output logic [7:0] count_o,
  output logic [7:0] presc_o
);

  jy_irq_state_e state_q, state_d;
  logic [7:0] mode_q, mode_d;
  logic [7:0] presc_q, presc_d;
  logic [7:0] count_q, count_d;
  logic [7:0] xor_q, xor_d;

  logic       tick_s;
  logic       wr_s;
  logic       dis_s;
  logic       ena_s;
  logic       ld_presc_s;
  logic       ld_count_s;
  logic [1:0] dir_s;
  logic       up_s;
  logic       step_en_s;
  jy_step_t   pstep_s;
  logic       wrap_s;

  jy_irq_source #(
    .A12_FILTER (A12_FILTER)
  ) u_source (
    .clk         (clk),
    .reset       (reset),
    .ce_i        (ce),
    .ppu_ce_i    (ppu_ce),
    .prg_write_i (prg_write),
    .chr_read_i  (chr_read),
    .chr_a12_i   (chr_a12),
    .src_i       (mode_q[MODE_SRC_HI:MODE_SRC_LO]),
    .tick_o      (tick_s)
  );

  assign wr_s       = ce && reg_wr;
  assign dis_s      = wr_s && (((reg_addr == REG_ENABLE_CTL) && !reg_din[0]) ||
                               (reg_addr == REG_DISABLE));
  assign ena_s      = wr_s && (((reg_addr == REG_ENABLE_CTL) && reg_din[0]) ||
                               (reg_addr == REG_ENABLE));
  assign ld_presc_s = wr_s && (reg_addr == REG_PRESC);
  assign ld_count_s = wr_s && (reg_addr == REG_COUNT);

  assign dir_s     = mode_q[MODE_DIR_HI:MODE_DIR_LO];
  assign up_s      = (dir_s == DIR_UP);
  assign step_en_s = tick_s && (state_q != JY_IRQ_OFF) &&
                     ((dir_s == DIR_UP) || (dir_s == DIR_DOWN));
  assign pstep_s   = presc_step(presc_q, up_s, mode_q[MODE_PRE3]);
  assign wrap_s    = pstep_s.carry && (up_s ? (count_q == 8'hFF) : (count_q == 8'h00));

  // Next-state: disable beats loads, loads swallow the tick, enable is last
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    presc_d = presc_q;
    count_d = count_q;
    xor_d   = xor_q;

    if (wr_s && (reg_addr == REG_MODE)) begin
      mode_d = reg_din;
    end else begin
      mode_d = mode_q;
    end

    if (wr_s && (reg_addr == REG_XOR)) begin
      xor_d = reg_din;
    end else begin
      xor_d = xor_q;
    end

    if (dis_s) begin
      state_d = JY_IRQ_OFF;
      presc_d = 8'h00;
    end else if (ld_presc_s) begin
      presc_d = reg_din ^ xor_q;
    end else if (ld_count_s) begin
      count_d = reg_din ^ xor_q;
    end else if (step_en_s) begin
      presc_d = pstep_s.value;
      if (pstep_s.carry) begin
        count_d = up_s ? (count_q + 8'd1) : (count_q - 8'd1);
      end else begin
        count_d = count_q;
      end
      if (wrap_s) begin
        state_d = JY_IRQ_PEND;
      end else begin
        state_d = state_q;
      end
    end else begin
      state_d = state_q;
    end

    if (!dis_s && ena_s && (state_q == JY_IRQ_OFF)) begin
      state_d = JY_IRQ_RUN;
    end else begin
      state_d = state_d;
    end
  end

  // Timer state and register file
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= JY_IRQ_OFF;
      mode_q  <= 8'h00;
      presc_q <= 8'h00;
      count_q <= 8'h00;
      xor_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      presc_q <= presc_d;
      count_q <= count_d;
      xor_q   <= xor_d;
    end
  end

  assign irq     = (state_q == JY_IRQ_PEND);
  assign mode_o  = mode_q;
  assign count_o = count_q;
  assign presc_o = presc_q;

endmodule

// File: tb/tb_jy_irq_timer.sv
// Bench for jy_irq_timer: two instances (A12 filter 0 and 3) share stimulus and
// are compared every cycle against an arithmetic model of the timer.
module tb_jy_irq_timer;

  localparam int FILT [2] = '{0, 3};

  logic       clk;
  logic       reset;
  logic       ce;
  logic       ppu_ce;
  logic       reg_wr;
  logic [2:0] reg_addr;
  logic [7:0] reg_din;
  logic       prg_write;
  logic       chr_read;
  logic       chr_a12;
  logic [1:0] irq_w;
  logic [7:0] mode_w  [2];
  logic [7:0] count_w [2];
  logic [7:0] presc_w [2];

  int n_checks;
  int n_fail;

  jy_irq_timer #(.A12_FILTER(0)) dut0 (
    .clk(clk), .reset(reset), .ce(ce), .ppu_ce(ppu_ce), .reg_wr(reg_wr),
    .reg_addr(reg_addr), .reg_din(reg_din), .prg_write(prg_write),
    .chr_read(chr_read), .chr_a12(chr_a12), .irq(irq_w[0]),
    .mode_o(mode_w[0]), .count_o(count_w[0]), .presc_o(presc_w[0])
  );

  jy_irq_timer #(.A12_FILTER(3)) dut1 (
    .clk(clk), .reset(reset), .ce(ce), .ppu_ce(ppu_ce), .reg_wr(reg_wr),
    .reg_addr(reg_addr), .reg_din(reg_din), .prg_write(prg_write),
    .chr_read(chr_read), .chr_a12(chr_a12), .irq(irq_w[1]),
    .mode_o(mode_w[1]), .count_o(count_w[1]), .presc_o(presc_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // st: 0 = off, 1 = counting, 2 = counting with irq
  typedef struct {
    int st; int mode; int presc; int cnt; int xr; int hist; int lowrun;
  } mdl_t;

  mdl_t m [2];

  function automatic mdl_t model_step(input mdl_t o, input int filt);
    mdl_t n = o;
    bit w, dis, ena, pulse, a12p, wrap;
    int dir, period, a, d;
    a   = int'(reg_addr);
    d   = int'(reg_din);
    w   = ce && reg_wr;
    dis = w && ((a == 0 && d % 2 == 0) || a == 2);
    ena = w && ((a == 0 && d % 2 == 1) || a == 3);
    a12p = ppu_ce && chr_a12 && o.hist == 0 && o.lowrun >= filt;
    if (ppu_ce) begin
      n.hist   = chr_a12 ? 1 : 0;
      n.lowrun = chr_a12 ? 0 : (o.lowrun < 1000 ? o.lowrun + 1 : o.lowrun);
    end
    case (o.mode % 4)
      0: pulse = ce;
      1: pulse = a12p;
      2: pulse = ppu_ce && chr_read;
      default: pulse = ce && prg_write;
    endcase
    dir    = o.mode / 64;
    period = ((o.mode / 4) % 2 == 1) ? 8 : 256;
    wrap   = 0;
    if (w && a == 1) n.mode = d;
    if (w && a == 6) n.xr = d;
    if (dis) begin
      n.st = 0; n.presc = 0;
    end else if (w && a == 4) begin
      n.presc = d ^ o.xr;
    end else if (w && a == 5) begin
      n.cnt = d ^ o.xr;
    end else if (pulse && o.st != 0 && (dir == 1 || dir == 2)) begin
      if (dir == 1) begin
        n.presc = (o.presc + 1) % 256;
        if (o.presc % period == period - 1) begin
          n.cnt = (o.cnt + 1) % 256;
          wrap  = (o.cnt == 255);
        end
      end else begin
        n.presc = (o.presc + 255) % 256;
        if (o.presc % period == 0) begin
          n.cnt = (o.cnt + 255) % 256;
          wrap  = (o.cnt == 0);
        end
      end
      if (wrap) n.st = 2;
    end
    if (!dis && ena && o.st == 0) n.st = 1;
    return n;
  endfunction

  // Model advances on the same edges as the DUT
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) m[i] <= '{0, 0, 0, 0, 0, 0, 0};
    end else begin
      for (int i = 0; i < 2; i++) m[i] <= model_step(m[i], FILT[i]);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("irq[%0d]", i), {7'd0, irq_w[i]}, (m[i].st == 2) ? 8'd1 : 8'd0);
      chk($sformatf("mode[%0d]", i), mode_w[i], 8'(m[i].mode));
      chk($sformatf("count[%0d]", i), count_w[i], 8'(m[i].cnt));
      chk($sformatf("presc[%0d]", i), presc_w[i], 8'(m[i].presc));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_in();
    ce = 1'b0; ppu_ce = 1'b0; reg_wr = 1'b0; reg_addr = 3'd0; reg_din = 8'd0;
    prg_write = 1'b0; chr_read = 1'b0; chr_a12 = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    ce = 1'b1; reg_wr = 1'b1; reg_addr = a; reg_din = d;
    cyc();
    ce = 1'b0; reg_wr = 1'b0;
  endtask

  task automatic ce_pulses(input int n);
    ce = 1'b1;
    for (int k = 0; k < n; k++) cyc();
    ce = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle_in();
    reset = 1'b1;
    #12;
    chk("reset_irq", {7'd0, irq_w[0]}, 8'd0);
    chk("reset_count", count_w[0], 8'h00);
    reset = 1'b0;
    cyc();

    // Up count from FE/FE: enable cycle tick not counted
    wr(3'd1, 8'h40);
    wr(3'd5, 8'hFE);
    wr(3'd4, 8'hFE);
    wr(3'd3, 8'h00);
    ce_pulses(2);
    chk("up_cnt_ff", count_w[0], 8'hFF);
    chk("up_presc_00", presc_w[0], 8'h00);
    ce_pulses(255);
    chk("up_noirq_yet", {7'd0, irq_w[0]}, 8'd0);
    ce_pulses(1);
    chk("up_wrap_cnt", count_w[0], 8'h00);
    chk("up_wrap_irq", {7'd0, irq_w[0]}, 8'd1);

    // Down, 3-bit prescaler, immediate borrow and wrap
    wr(3'd2, 8'h00);
    wr(3'd1, 8'h84);
    wr(3'd4, 8'h00);
    wr(3'd5, 8'h00);
    wr(3'd3, 8'h00);
    ce_pulses(1);
    chk("dn_presc", presc_w[0], 8'hFF);
    chk("dn_cnt", count_w[0], 8'hFF);
    chk("dn_irq", {7'd0, irq_w[0]}, 8'd1);

    // Xor applied to loads; a load swallows the concurrent tick
    wr(3'd6, 8'h55);
    wr(3'd5, 8'h55);
    chk("xor_cnt", count_w[0], 8'h00);
    wr(3'd4, 8'h12);
    chk("xor_presc", presc_w[0], 8'h47);

    // Disable from PEND, then re-enable and resume counting
    wr(3'd2, 8'h00);
    chk("dis_irq", {7'd0, irq_w[0]}, 8'd0);
    chk("dis_presc", presc_w[0], 8'h00);
    wr(3'd3, 8'h00);
    ce_pulses(3);
    chk("resume_presc", presc_w[0], 8'hFD);
    chk("resume_cnt", count_w[0], 8'hFF);

    // A12 source: four rises after two low PPU cycles each
    wr(3'd2, 8'h00);
    wr(3'd6, 8'h00);
    wr(3'd1, 8'h41);
    wr(3'd5, 8'h00);
    wr(3'd3, 8'h00);
    ppu_ce = 1'b1;
    for (int r = 0; r < 4; r++) begin
      chr_a12 = 1'b0; cyc(); cyc();
      chr_a12 = 1'b1; cyc();
    end
    ppu_ce = 1'b0; chr_a12 = 1'b0;
    chk("a12_nofilt", presc_w[0], 8'h04);
    chk("a12_filt3", presc_w[1], 8'h00);

    // Async reset mid-run
    wr(3'd2, 8'h00);
    wr(3'd1, 8'h40);
    wr(3'd5, 8'h80);
    wr(3'd3, 8'h00);
    ce_pulses(3);
    reset = 1'b1;
    #1;
    chk("rst_irq", {7'd0, irq_w[0]}, 8'd0);
    chk("rst_mode", mode_w[0], 8'h00);
    chk("rst_cnt", count_w[0], 8'h00);
    chk("rst_presc", presc_w[0], 8'h00);
    cyc();
    reset = 1'b0;
    ce_pulses(5);
    chk("post_rst_presc", presc_w[0], 8'h00);
    chk("post_rst_cnt", count_w[0], 8'h00);

    // Randomized traffic
    for (int c = 0; c < 6000; c++) begin
      ce        = ($urandom % 2) == 0;
      ppu_ce    = ($urandom % 2) == 0;
      reg_wr    = ($urandom % 6) == 0;
      reg_addr  = 3'($urandom % 8);
      reg_din   = 8'($urandom);
      if (reg_addr == 3'd1 && ($urandom % 2) == 0) reg_din[7:6] = 2'b01;
      if (reg_addr == 3'd2 && ($urandom % 3) != 0) reg_addr = 3'd3;
      prg_write = ($urandom % 3) == 0;
      chr_read  = ($urandom % 2) == 0;
      chr_a12   = ($urandom % 3) == 0;
      if (($urandom % 800) == 0) begin
        reset = 1'b1;
        cyc();
        reset = 1'b0;
      end else begin
        cyc();
      end
    end
    idle_in();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jy_irq_timer.md
# jy_irq_timer

Standalone IRQ timer for J.Y. Company mappers (90/209/211/35), replacing the inline prescaler/counter logic in the mapper top level. It decodes the $C000-$C007 register window, selects one of four clock sources (CPU M2, PPU A12 rise, PPU read, CPU write) and steps an 8-bit or 3-bit prescaler. When the prescaler wraps it steps an 8-bit counter, and a counter wrap raises a sticky IRQ. The mapper top instantiates it and drives `irq_b` from `irq`.

## Interface
Parameters:
- `A12_FILTER`, default 0, minimum ppu_ce count A12 must stay low before a rising edge counts (0 = no filter).

Ports:
- `clk` in 1, system clock.
- `reset` in 1, asynchronous, active-high.
- `ce` in 1, CPU M2 cycle enable.
- `ppu_ce` in 1, PPU cycle enable.
- `reg_wr` in 1, write to $C000-$C007, decoded upstream; honoured only when `ce`.
- `reg_addr` in 3, `prg_ain[2:0]`.
- `reg_din` in 8, CPU write data.
- `prg_write` in 1, any CPU write (source mode 3).
- `chr_read` in 1, PPU read strobe.
- `chr_a12` in 1, PPU address bit 12.
- `irq` out 1, IRQ request, active-high.
- `mode_o` in/out: out 8, current mode register.
- `count_o` out 8, current counter.
- `presc_o` out 8, current prescaler.

Clock and reset are decided as stated: one clock; reset is asynchronous and active-high.

## Operation
Register writes (on `ce && reg_wr`):
- 0 ($C000): `din[0]` set requests enable; clear requests disable.
- 1 ($C001): mode. Fields:
  - [7:6] direction: 01 up, 10 down, 00/11 halt.
  - [2] 3-bit prescaler when set.
  - [1:0] source: 0 CPU `ce`, 1 A12 rise, 2 `ppu_ce && chr_read`, 3 `ce && prg_write`.
- 2: disable.
- 3: enable.
- 4: prescaler <= din ^ xor.
- 5: counter <= din ^ xor.
- 6: xor <= din.
- 7: ignored.

States:
- OFF: `irq`=0, no counting.
- RUN: counting.
- PEND: `irq`=1, counting continues.

Transitions:
- Disable (any state) -> OFF. Also clears the prescaler to 0. The counter and xor are kept.
- Enable: OFF -> RUN. RUN and PEND are unchanged.
- RUN -> PEND on a counter wrap.

Tick rule, applied when a source pulse occurs in RUN/PEND and direction is not halt:
- Up:
  - Prescaler increments.
  - Carry is taken when the old prescaler is FF (8-bit) or old [2:0] is 7 (3-bit). In 3-bit mode the full 8 bits still increment.
  - On carry the counter increments; old counter FF -> wrap.
- Down:
  - Prescaler decrements.
  - Borrow is taken when the old prescaler is 00, or old [2:0] is 0 in 3-bit mode.
  - On borrow the counter decrements; old counter 00 -> wrap.

A12 source:
- `chr_a12` is sampled into a history bit on each `ppu_ce`.
- A pulse occurs when `ppu_ce`, `chr_a12`=1, the history bit is 0, and the low-run count is at least `A12_FILTER`.

Priority in one cycle, highest first:
1. Disable.
2. Register write to the prescaler/counter. The written value is loaded and that cycle's tick is discarded.
3. Tick.
4. Enable.

Only one register write can occur per cycle.

Reset values: state OFF, mode/prescaler/counter/xor 00, history 0, `irq` 0, all debug outputs 0.

## Timing
- Register writes and ticks take effect at the edge that samples them.
- `irq` is decoded from the state register, so it rises one cycle after the wrapping tick and falls one cycle after the disable write.
- Reset asserted mid-count: all state clears immediately (async). After reset releases, counting needs a fresh enable write.
- A tick on the same cycle as an enable write in OFF is not counted. Counting starts on the next pulse.

## Structure
- Package `jy_irq_pkg`:
  - state enum (`JY_IRQ_OFF`, `JY_IRQ_RUN`, `JY_IRQ_PEND`)
  - register offset constants
  - mode field positions
  - source codes
- Sub-module `jy_irq_source`: A12 history/filter and the four-way source mux, producing a one-cycle `tick`.
- The top contains the register file, the FSM and the prescaler/counter arithmetic.

## Test plan
- Mode=0x40, counter write 0xFE, prescaler 0xFE, enable, 2 ce pulses -> counter FF. After 256 more ce pulses -> counter 00 and `irq`=1 one cycle later.
- Mode=0x84 (down, 3-bit), prescaler 0x00, counter 0x00, enable, 1 ce pulse -> prescaler FF, counter FF, `irq`=1.
- Xor=0x55, counter write 0x55 -> `count_o`=0x00. Prescaler write on the same cycle as a tick -> `presc_o` equals the written value ^ xor.
- Source 1, A12 toggled 0->1 four times with `A12_FILTER`=0 -> 4 ticks. With `A12_FILTER`=3 and A12 low for 2 ppu_ce between highs -> 0 ticks.
- State PEND, write $C002 -> `irq` 0 next cycle, `presc_o` 0. Write $C003 -> RUN and counting resumes.
- Reset asserted while RUN with counter 0x80 -> `irq` and all debug outputs 0 immediately. Ticks after release -> no counting until enable.
